fp_divide_seq: RTL and testbench



---
 rtl/fp_divide_seq.sv | 133 +++++++++++++
 tb/tb_fp_divide_seq.sv | 132 +++++++++++++
 2 files changed

// File: rtl/fp_divide_seq.sv
// Iterative FP32 divider (result = a / b): restoring mantissa division, one quotient bit per cycle.
// Implicit leading one, no denormals, truncation, exponent wraps mod 256.
module fp_divide_seq #(
  parameter int EXP_BIAS = 127,
  parameter int QBITS    = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        valid,
  output logic [31:0] result,
  output logic        div_by_zero
);

  localparam int CW = $clog2(QBITS);

  typedef enum logic [1:0] {IDLE, DIVIDE, NORMALIZE, DONE} state_t;

  state_t      state_q, state_d;
  logic        sign_q, sign_d;
  logic [7:0]  exp_q, exp_d;
  logic [24:0] rem_q, rem_d;
  logic [23:0] div_q, div_d;
  logic [24:0] quo_q, quo_d;
  logic [CW-1:0] count_q, count_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic [31:0] result_q, result_d;
  logic        dbz_q, dbz_d;

  logic [24:0] diff;
  logic        ge;
  logic        sign_in;
  logic [7:0]  exp_in;
  logic [7:0]  exp_norm;

  assign diff     = rem_q - {1'b0, div_q};
  assign ge       = (rem_q >= {1'b0, div_q});
  assign sign_in  = a[31] ^ b[31];
  assign exp_in   = a[30:23] - b[30:23] + 8'(EXP_BIAS);
  assign exp_norm = quo_q[24] ? exp_q : exp_q - 8'd1;

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    rem_d    = rem_q;
    div_d    = div_q;
    quo_d    = quo_q;
    count_d  = count_q;
    result_d = result_q;
    dbz_d    = dbz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          sign_d = sign_in;
          exp_d  = exp_in;
          // Divisor zero outranks dividend zero so 0/0 reports div_by_zero.
          if (b[30:0] == 31'h0) begin
            state_d  = DONE;
            dbz_d    = 1'b1;
            result_d = (a[30:0] == 31'h0) ? 32'h7FC0_0000 : {sign_in, 8'hFF, 23'h0};
          end else if (a[30:0] == 31'h0) begin
            state_d  = DONE;
            dbz_d    = 1'b0;
            result_d = 32'h0;
          end else begin
            state_d = DIVIDE;
            rem_d   = {2'b01, a[22:0]};
            div_d   = {1'b1, b[22:0]};
            quo_d   = '0;
            count_d = CW'(QBITS - 1);
          end
        end
      end
      DIVIDE: begin
        // Quotient bits shift in MSB first, so after QBITS steps quo_q holds the full quotient.
        quo_d = {quo_q[23:0], ge};
        rem_d = ge ? {diff[23:0], 1'b0} : {rem_q[23:0], 1'b0};
        if (count_q == '0) state_d = NORMALIZE;
        else               count_d = count_q - 1'b1;
      end
      NORMALIZE: begin
        result_d = {sign_q, exp_norm, quo_q[24] ? quo_q[23:1] : quo_q[22:0]};
        dbz_d    = 1'b0;
        state_d  = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d != IDLE);
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      quo_q    <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      quo_q    <= quo_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign valid       = valid_q;
  assign result      = result_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fp_divide_seq.sv
// Directed bench for fp_divide_seq: hand-computed quotients, special operands, latency,
// ignored start, mid-operation reset and back-to-back operation.
module tb_fp_divide_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a, b;
  logic        busy, valid, div_by_zero;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

  fp_divide_seq dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .valid(valid), .result(result), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one operation, then wait (bounded) for valid and check latency and outputs.
  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic [31:0] er, input logic edz, input int elat);
    int lat;
    bit seen;
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; a = $urandom; b = $urandom;
    lat = 0; seen = 0;
    while (!seen && lat < 60) begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk({tag, "_busy"}, 32'(busy), 32'd1);
      if (valid) seen = 1;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(elat));
    chk({tag, "_res"}, result, er);
    chk({tag, "_dbz"}, 32'(div_by_zero), 32'(edz));
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(valid), 32'd0);
    chk({tag, "_hold"}, result, er);
  endtask

  initial begin
    int n, nval, vlat, gap, held_err;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk); rst = 1'b0;

    run_op("six_two",  32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 27);
    run_op("one_three", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 1'b0, 27);
    run_op("neg8_half", 32'hC100_0000, 32'h3F00_0000, 32'hC180_0000, 1'b0, 27);
    run_op("exp_wrap", 32'h7F00_0000, 32'h0080_0000, 32'h3E00_0000, 1'b0, 27);
    run_op("frac_ones", 32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h3F80_0000, 1'b0, 27);
    run_op("x_div_0",  32'h3F80_0000, 32'h8000_0000, 32'hFF80_0000, 1'b1, 1);
    run_op("zero_zero", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b1, 1);
    run_op("zero_x",   32'h8000_0000, 32'h40A0_0000, 32'h0000_0000, 1'b0, 1);

    // Start pulse while busy must be ignored.
    @(negedge clk);
    a = 32'h40C0_0000; b = 32'h4000_0000; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    nval = 0; vlat = 0;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (i == 10) begin a = 32'h3F80_0000; b = 32'h4040_0000; start = 1'b1; end
      if (i == 11) start = 1'b0;
      if (valid) begin nval++; if (vlat == 0) vlat = i; end
    end
    chk("ign_nvalid", 32'(nval), 32'd1);
    chk("ign_lat", 32'(vlat), 32'd27);
    chk("ign_res", result, 32'h4040_0000);

    // Reset mid-operation aborts with no valid pulse.
    @(negedge clk);
    a = 32'h3F80_0000; b = 32'h4040_0000; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 1; i <= 12; i++) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_result", result, 32'h0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(valid), 32'd0);
    @(negedge clk); rst = 1'b0;
    nval = 0;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      if (valid) nval++;
    end
    chk("abort_novalid", 32'(nval), 32'd0);
    run_op("post_abort", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 27);

    // Back-to-back: second start in the IDLE cycle right after valid.
    @(negedge clk);
    a = 32'h3F80_0000; b = 32'h4040_0000; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (!valid && n < 60) begin @(negedge clk); n++; end
    chk("b2b_first", 32'(n), 32'd27);
    @(posedge clk); #1;
    a = 32'h40C0_0000; b = 32'h4000_0000; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    gap = 1; held_err = 0;
    while (gap < 60) begin
      @(negedge clk);
      gap++;
      if (valid) break;
      if (result !== 32'h3EAA_AAAA) held_err++;
    end
    chk("b2b_gap", 32'(gap), 32'd28);
    chk("b2b_held", 32'(held_err), 32'd0);
    chk("b2b_res", result, 32'h4040_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
